// File: rtl/wdog_pkg.sv
// Shared types and defaults for the multi-channel watchdog.
package wdog_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_EXPIRED  = 2'd2
  } wdog_state_e;

  localparam int unsigned WDOG_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/wdog_channel.sv
// One watchdog channel: kick detection, timeout counter, FSM and status flags.
// Optional window (minimum kick interval) check is built when WDOG_WINDOW_EN is defined.
module wdog_channel
  import wdog_pkg::*;
#(
  parameter int unsigned KICK_W      = 8,
  parameter int unsigned CNT_W       = WDOG_CNT_W_DEFAULT,
  parameter int unsigned WARN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [KICK_W-1:0] kick_slice,
  input  logic [CNT_W-1:0]  timeout,
  input  logic [CNT_W-1:0]  window_min,
  input  logic              clear,
  output logic              expired,
  output logic              warn,
  output logic              early_kick
);

  wdog_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [KICK_W-1:0] prev_q, prev_d;
  logic              expired_q, expired_d;
  logic              warn_q, warn_d;
  logic              early_q, early_d;

  logic              bus_kick;
  logic              kick;
  logic              at_limit;
  logic              violation;

  // A bus change is a kick; software clear while armed also restarts the count.
  assign bus_kick = (kick_slice != prev_q);
  assign kick     = bus_kick || clear;
  assign at_limit = (cnt_q >= (timeout - CNT_W'(1)));

`ifdef WDOG_WINDOW_EN
  // Bus kick arriving too soon after the previous one; clear never counts.
  assign violation = (window_min != '0) && bus_kick && !clear && (cnt_q < window_min);
`else
  logic unused_window;
  assign unused_window = ^window_min;
  assign violation     = 1'b0;
`endif

  // Next-state, counter and registered-flag computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_d    = kick_slice;
    early_d   = 1'b0;
    expired_d = 1'b0;
    warn_d    = 1'b0;

    unique case (state_q)
      ST_DISABLED: begin
        state_d = ST_ARMED;
        cnt_d   = '0;
      end
      ST_ARMED: begin
        if (violation) begin
          state_d = ST_EXPIRED;
          early_d = 1'b1;
        end else if (kick) begin
          cnt_d = '0;
        end else if (at_limit) begin
          state_d = ST_EXPIRED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXPIRED: begin
        if (clear) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_DISABLED;
        cnt_d   = '0;
      end
    endcase

    // Global enable and a zero timeout override everything, including clear.
    if (!ena || (timeout == '0)) begin
      state_d = ST_DISABLED;
      cnt_d   = '0;
      early_d = 1'b0;
    end

    expired_d = (state_d == ST_EXPIRED);
    if (state_d == ST_ARMED) begin
      if ({1'b0, timeout} <= (CNT_W+1)'(WARN_CYCLES)) begin
        warn_d = 1'b1;
      end else begin
        warn_d = ({1'b0, cnt_d} >= ({1'b0, timeout} - (CNT_W+1)'(WARN_CYCLES)));
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DISABLED;
      cnt_q     <= '0;
      prev_q    <= '0;
      expired_q <= 1'b0;
      warn_q    <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      expired_q <= expired_d;
      warn_q    <= warn_d;
      early_q   <= early_d;
    end
  end

  assign expired    = expired_q;
  assign warn       = warn_q;
  assign early_kick = early_q;

endmodule

// File: rtl/wdog_multi.sv
// Multi-channel watchdog top: one wdog_channel per activity bus plus a global fault OR.
// Optional window check enabled by defining WDOG_WINDOW_EN.
module wdog_multi
  import wdog_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned KICK_W      = 8,
  parameter int unsigned CNT_W       = WDOG_CNT_W_DEFAULT,
  parameter int unsigned WARN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [CHANNELS*KICK_W-1:0] kick_bus,
  input  logic [CNT_W-1:0]           timeout,
  input  logic [CNT_W-1:0]           window_min,
  input  logic [CHANNELS-1:0]        clear,
  output logic [CHANNELS-1:0]        expired,
  output logic [CHANNELS-1:0]        warn,
  output logic [CHANNELS-1:0]        early_kick,
  output logic                       any_expired
);

  // One independent channel per activity bus slice.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    wdog_channel #(
      .KICK_W      (KICK_W),
      .CNT_W       (CNT_W),
      .WARN_CYCLES (WARN_CYCLES)
    ) u_channel (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .kick_slice (kick_bus[i*KICK_W +: KICK_W]),
      .timeout    (timeout),
      .window_min (window_min),
      .clear      (clear[i]),
      .expired    (expired[i]),
      .warn       (warn[i]),
      .early_kick (early_kick[i])
    );
  end

  assign any_expired = |expired;

endmodule

// File: tb/tb_wdog_multi.sv
// Directed self-checking bench for wdog_multi (2 channels, timeout 10, warn 2).
module tb_wdog_multi;

  localparam int unsigned CH = 2;
  localparam int unsigned KW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned WC = 2;

`ifdef WDOG_WINDOW_EN
  localparam bit WIN = 1'b1;
`else
  localparam bit WIN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic [KW-1:0]    bus0, bus1;
  logic [CH*KW-1:0] kick_bus;
  logic [CW-1:0]    timeout;
  logic [CW-1:0]    window_min;
  logic [CH-1:0]    clear;
  logic [CH-1:0]    expired;
  logic [CH-1:0]    warn;
  logic [CH-1:0]    early_kick;
  logic             any_expired;

  int n_checks = 0;
  int n_fail   = 0;

  assign kick_bus = {bus1, bus0};

  always #5 clk = ~clk;

  wdog_multi #(
    .CHANNELS    (CH),
    .KICK_W      (KW),
    .CNT_W       (CW),
    .WARN_CYCLES (WC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .kick_bus    (kick_bus),
    .timeout     (timeout),
    .window_min  (window_min),
    .clear       (clear),
    .expired     (expired),
    .warn        (warn),
    .early_kick  (early_kick),
    .any_expired (any_expired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    ena        = 1'b0;
    bus0       = '0;
    bus1       = '0;
    timeout    = CW'(10);
    window_min = '0;
    clear      = '0;

    // Reset state
    step(); step();
    check("rst_expired", 32'(expired), 32'h0);
    check("rst_warn", 32'(warn), 32'h0);
    check("rst_early", 32'(early_kick), 32'h0);
    check("rst_any", 32'(any_expired), 32'h0);
    rst = 1'b0;

    // Constant bus: arm on edge 1, warn on 9..10, expire on 11
    ena = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      step();
      check($sformatf("basic_exp_e%0d", e), 32'(expired), (e == 11) ? 32'h3 : 32'h0);
      check($sformatf("basic_warn_e%0d", e), 32'(warn), (e == 9 || e == 10) ? 32'h3 : 32'h0);
    end
    check("basic_any", 32'(any_expired), 32'h1);
    check("basic_early", 32'(early_kick), 32'h0);

    // Clear both, then keep ch0 alive with a kick every 9 cycles; ch1 expires
    clear = 2'b11;
    step();
    clear = 2'b00;
    check("clr_both_exp", 32'(expired), 32'h0);
    for (int i = 1; i <= 100; i++) begin
      if (((i - 1) % 9) == 0) bus0 = (bus0 == 8'hAA) ? 8'hAB : 8'hAA;
      step();
      check($sformatf("alive_ch0_i%0d", i), 32'(expired[0]), 32'h0);
      check($sformatf("alive_ch1_i%0d", i), 32'(expired[1]), (i >= 10) ? 32'h1 : 32'h0);
    end

    // Last kick at the final loop edge: ch0 expires 10 edges later
    for (int e = 1; e <= 10; e++) begin
      step();
      check($sformatf("idle_ch0_e%0d", e), 32'(expired[0]), (e == 10) ? 32'h1 : 32'h0);
      check($sformatf("idle_warn0_e%0d", e), 32'(warn[0]), (e == 8 || e == 9) ? 32'h1 : 32'h0);
    end

    // Clear ch0 only: falls next edge, re-expires 10 edges after the clear
    clear = 2'b01;
    step();
    clear = 2'b00;
    check("clr0_exp", 32'(expired), 32'h2);
    for (int e = 1; e <= 10; e++) begin
      step();
      check($sformatf("reexp_ch0_e%0d", e), 32'(expired[0]), (e == 10) ? 32'h1 : 32'h0);
    end

    // Kick lands exactly on the would-be expiry edge
    clear = 2'b01;
    step();
    clear = 2'b00;
    for (int e = 1; e <= 9; e++) step();
    check("edge_warn_pre", 32'(warn[0]), 32'h1);
    bus0 = bus0 ^ 8'h01;
    step();
    check("edge_kick_noexp", 32'(expired[0]), 32'h0);
    check("edge_kick_nowarn", 32'(warn[0]), 32'h0);
    for (int e = 1; e <= 10; e++) begin
      step();
      check($sformatf("edge_next_e%0d", e), 32'(expired[0]), (e == 10) ? 32'h1 : 32'h0);
    end

    // Window check: legal kick at cnt 5, then an early kick 2 cycles later
    window_min = CW'(4);
    clear      = 2'b01;
    step();
    clear = 2'b00;
    for (int e = 1; e <= 5; e++) step();
    bus0 = bus0 ^ 8'h01;
    step();
    check("win_legal_early", 32'(early_kick[0]), 32'h0);
    check("win_legal_exp", 32'(expired[0]), 32'h0);
    step();
    bus0 = bus0 ^ 8'h01;
    step();
    check("win_viol_early", 32'(early_kick[0]), WIN ? 32'h1 : 32'h0);
    check("win_viol_exp", 32'(expired[0]), WIN ? 32'h1 : 32'h0);
    step();
    check("win_pulse_end", 32'(early_kick[0]), 32'h0);
    check("win_exp_hold", 32'(expired[0]), WIN ? 32'h1 : 32'h0);
    window_min = '0;

    // ena drop together with clear: DISABLED wins, all flags low next edge
    check("pre_ena_ch1", 32'(expired[1]), 32'h1);
    ena   = 1'b0;
    clear = 2'b11;
    step();
    clear = 2'b00;
    check("ena_off_exp", 32'(expired), 32'h0);
    check("ena_off_warn", 32'(warn), 32'h0);
    check("ena_off_any", 32'(any_expired), 32'h0);
    step();
    check("ena_off_hold", 32'(expired), 32'h0);

    // Asynchronous reset while warn is asserted
    ena = 1'b1;
    for (int e = 1; e <= 9; e++) step();
    check("pre_rst_warn", 32'(warn), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_warn", 32'(warn), 32'h0);
    check("async_rst_exp", 32'(expired), 32'h0);
    step();
    rst = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      step();
      check($sformatf("post_rst_e%0d", e), 32'(expired), (e == 11) ? 32'h3 : 32'h0);
    end
    check("post_rst_any", 32'(any_expired), 32'h1);

    // timeout = 0 holds everything disabled
    timeout = '0;
    step();
    check("tmo0_exp", 32'(expired), 32'h0);
    check("tmo0_warn", 32'(warn), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
